// File: rtl/ioctl_region_loader_pkg.sv
// Shared types and helpers for the ioctl download front end.
package ioctl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      HOLD
   } state_t;

   localparam logic [7:0] ROM_INDEX_DEFAULT = 8'd0;
   localparam logic [7:0] DIP_INDEX_DEFAULT = 8'd254;

   // Upper bounds used by the width-independent region lookup.
   localparam int unsigned MAX_REGIONS = 8;
   localparam int unsigned MAX_ADDR_W  = 32;

   typedef struct packed {
      logic                   hit;
      logic [MAX_REGIONS-1:0] sel;
      logic [MAX_ADDR_W-1:0]  base;
   } region_sel_t;

   // Lowest region whose exclusive end lies above addr; base is the previous end.
   function automatic region_sel_t region_of(
      input logic [MAX_ADDR_W-1:0]             addr,
      input logic [MAX_REGIONS*MAX_ADDR_W-1:0] bounds,
      input int unsigned                       nreg
   );
      region_sel_t           r;
      logic [MAX_ADDR_W-1:0] lo;
      r  = '0;
      lo = '0;
      for (int unsigned i = 0; i < MAX_REGIONS; i++) begin
         if (i < nreg && !r.hit && addr < bounds[i*MAX_ADDR_W +: MAX_ADDR_W]) begin
            r.hit    = 1'b1;
            r.sel[i] = 1'b1;
            r.base   = lo;
         end
         lo = bounds[i*MAX_ADDR_W +: MAX_ADDR_W];
      end
      return r;
   endfunction

endpackage

// File: rtl/ioctl_region_loader_if.sv
// ioctl download stream as driven by hps_io.
interface ioctl_region_loader_if #(
   parameter int unsigned ADDR_W = 25
);
   logic              ioctl_download;
   logic              ioctl_wr;
   logic [ADDR_W-1:0] ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic [7:0]        ioctl_index;

   modport master (
      output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index
   );

   modport slave (
      input ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index
   );
endinterface

// File: rtl/ioctl_region_decode.sv
// Combinational map of a download address to a one-hot region and region-relative address.
module ioctl_region_decode
   import ioctl_pkg::*;
#(
   parameter int unsigned                    NUM_REGIONS = 4,
   parameter int unsigned                    ADDR_W      = 25,
   parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_END  = {25'h0A000, 25'h08000, 25'h06000, 25'h04000}
) (
   input  logic [ADDR_W-1:0]      addr_i,
   output logic [NUM_REGIONS-1:0] sel_o,
   output logic [ADDR_W-1:0]      rel_addr_o,
   output logic                   hit_o
);

   logic [MAX_REGIONS*MAX_ADDR_W-1:0] bounds;
   logic [MAX_ADDR_W-1:0]             addr_ext;
   logic [MAX_ADDR_W-1:0]             diff;
   region_sel_t                       r;

   // Widen the bounds and address to the package lookup width, then slice results back.
   always_comb begin
      bounds   = '0;
      addr_ext = '0;
      for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
         bounds[i*MAX_ADDR_W +: ADDR_W] = REGION_END[i*ADDR_W +: ADDR_W];
      end
      addr_ext[ADDR_W-1:0] = addr_i;
      r          = region_of(addr_ext, bounds, NUM_REGIONS);
      diff       = addr_ext - r.base;
      sel_o      = r.sel[NUM_REGIONS-1:0];
      rel_addr_o = diff[ADDR_W-1:0];
      hit_o      = r.hit;
   end

endmodule

// File: rtl/ioctl_region_loader.sv
// Download front end: routes ROM bytes to regions, captures DIP bytes, holds the core.
module ioctl_region_loader
   import ioctl_pkg::*;
#(
   parameter int unsigned                   NUM_REGIONS = 4,
   parameter int unsigned                   ADDR_W      = 25,
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_END  = {25'h0A000, 25'h08000, 25'h06000, 25'h04000},
   parameter logic [7:0]                    ROM_INDEX   = ROM_INDEX_DEFAULT,
   parameter logic [7:0]                    DIP_INDEX   = DIP_INDEX_DEFAULT,
   parameter int unsigned                   DIP_BYTES   = 8,
   parameter logic [DIP_BYTES*8-1:0]        DIP_DEFAULT = '0,
   parameter int unsigned                   HOLD_CYCLES = 16
) (
   input  logic                     clk_sys,
   input  logic                     reset,
   ioctl_region_loader_if.slave     ioctl,
   output logic [NUM_REGIONS-1:0]   rom_we,
   output logic [ADDR_W-1:0]        rom_addr,
   output logic [7:0]               rom_data,
   output logic [DIP_BYTES*8-1:0]   dip_sw,
   output logic                     core_hold,
   output logic                     rom_valid,
   output logic                     overflow
);

   localparam logic [ADDR_W-1:0] END_LAST = REGION_END[(NUM_REGIONS-1)*ADDR_W +: ADDR_W];
   localparam int unsigned       HC_W     = $clog2(HOLD_CYCLES + 1);

   state_t                 state_q, state_d;
   logic [HC_W-1:0]        hold_q, hold_d;
   logic                   dl_q;
   logic [7:0]             idx_q, idx_d;
   logic [ADDR_W-1:0]      count_q, count_d;
   logic [NUM_REGIONS-1:0] rom_we_q, rom_we_d;
   logic [ADDR_W-1:0]      rom_addr_q, rom_addr_d;
   logic [7:0]             rom_data_q, rom_data_d;
   logic [DIP_BYTES*8-1:0] dip_q, dip_d;
   logic                   hold_out_q, hold_out_d;
   logic                   valid_q, valid_d;
   logic                   ovf_q, ovf_d;

   logic                   rise, fall, start;
   logic [NUM_REGIONS-1:0] sel;
   logic [ADDR_W-1:0]      rel_addr;
   logic                   hit;
   logic [ADDR_W-1:0]      addr_p1;

   assign rise    = ioctl.ioctl_download & ~dl_q;
   assign fall    = ~ioctl.ioctl_download & dl_q;
   assign start   = (state_q != LOAD) && (state_d == LOAD);
   assign addr_p1 = ioctl.ioctl_addr + 1'b1;

   ioctl_region_decode #(
      .NUM_REGIONS (NUM_REGIONS),
      .ADDR_W      (ADDR_W),
      .REGION_END  (REGION_END)
   ) u_decode (
      .addr_i     (ioctl.ioctl_addr),
      .sel_o      (sel),
      .rel_addr_o (rel_addr),
      .hit_o      (hit)
   );

   // State register, hold counter and download edge detector.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= IDLE;
         hold_q  <= '0;
         // Sampling the live level means a download already high across reset is not an edge.
         dl_q    <= ioctl.ioctl_download;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         dl_q    <= ioctl.ioctl_download;
      end
   end

   // Next-state logic: start on rise, hold on fall, release after the hold count.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      unique case (state_q)
         IDLE: if (rise) state_d = LOAD;
         LOAD: if (fall) begin
            state_d = HOLD;
            hold_d  = HC_W'(HOLD_CYCLES);
         end
         HOLD: begin
            if (rise) begin
               state_d = LOAD;
            end else begin
               hold_d = hold_q - 1'b1;
               if (hold_d == '0) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output/datapath next values: byte routing, DIP capture, counters and flags.
   always_comb begin
      idx_d      = idx_q;
      count_d    = count_q;
      rom_we_d   = '0;
      rom_addr_d = rom_addr_q;
      rom_data_d = rom_data_q;
      dip_d      = dip_q;
      valid_d    = valid_q;
      ovf_d      = ovf_q;
      hold_out_d = (state_d != IDLE);

      if (start) begin
         idx_d = ioctl.ioctl_index;
         if (ioctl.ioctl_index == ROM_INDEX) begin
            valid_d = 1'b0;
            ovf_d   = 1'b0;
            count_d = '0;
         end
      end

      if (state_q == LOAD && ioctl.ioctl_wr) begin
         if (idx_q == ROM_INDEX) begin
            if (hit) begin
               rom_we_d   = sel;
               rom_addr_d = rel_addr;
               rom_data_d = ioctl.ioctl_dout;
               if (addr_p1 > count_q) count_d = addr_p1;
            end else begin
               ovf_d = 1'b1;
            end
         end else if (idx_q == DIP_INDEX) begin
            for (int unsigned i = 0; i < DIP_BYTES; i++) begin
               if (ioctl.ioctl_addr == ADDR_W'(i)) dip_d[i*8 +: 8] = ioctl.ioctl_dout;
            end
         end
      end

      // Uses the _d values so a byte coincident with the fall is counted.
      if (state_q == LOAD && fall && idx_q == ROM_INDEX) begin
         valid_d = (count_d == END_LAST) && !ovf_d;
      end
   end

   // Registered outputs and persistent bank.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         idx_q      <= '0;
         count_q    <= '0;
         rom_we_q   <= '0;
         rom_addr_q <= '0;
         rom_data_q <= '0;
         dip_q      <= DIP_DEFAULT;
         hold_out_q <= 1'b0;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         count_q    <= count_d;
         rom_we_q   <= rom_we_d;
         rom_addr_q <= rom_addr_d;
         rom_data_q <= rom_data_d;
         dip_q      <= dip_d;
         hold_out_q <= hold_out_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
      end
   end

   assign rom_we    = rom_we_q;
   assign rom_addr  = rom_addr_q;
   assign rom_data  = rom_data_q;
   assign dip_sw    = dip_q;
   assign core_hold = hold_out_q;
   assign rom_valid = valid_q;
   assign overflow  = ovf_q;

endmodule
